// File: rtl/cache_dp_arbiter.sv
// Round-robin arbiter sharing a dual-port direct-mapped cache between NUM_REQ readers and one writer.
// Optional response hit/miss counters are built when CACHE_ARB_STATS_EN is defined.
module cache_dp_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IDX_BITS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            rd_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_REQ-1:0]            rd_ready_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_o,
    output logic [NUM_REQ-1:0]            rsp_hit_o,
    input  logic                          wr_valid_i,
    input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    output logic                          wr_ready_o,
    output logic [ADDR_WIDTH-1:0]         cache_addra_o,
    output logic [ADDR_WIDTH-1:0]         cache_addrb_o,
    output logic [DATA_WIDTH-1:0]         cache_wdata_o,
    output logic                          cache_cea_o,
    output logic                          cache_ceb_o,
    output logic                          cache_we_o,
    input  logic [DATA_WIDTH-1:0]         cache_rdataa_i,
    input  logic [DATA_WIDTH-1:0]         cache_rdatab_i,
    input  logic                          cache_rhita_i,
    input  logic                          cache_rhitb_i,
    output logic [31:0]                   hit_cnt_o,
    output logic [31:0]                   miss_cnt_o
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]            g0_idx, g1_idx;
    logic                        g0_found, g1_found;
    logic                        grant_b, grant_a, wr_en, fwd_hit;
    logic [ADDR_WIDTH-1:0]       req_addr [NUM_REQ];
    logic [NUM_REQ-1:0]          rd_grant;
    logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]          rsp_hit_q, rsp_hit_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_addr[gi] = rd_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign rd_grant[gi] = (grant_b && (g0_idx == PTR_W'(gi))) ||
                                  (grant_a && (g1_idx == PTR_W'(gi)));
        end
    endgenerate

    // Circular search from rr_ptr: first valid goes to port B, second to port A.
    always_comb begin
        int sum;
        logic [PTR_W-1:0] cand;
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        sum      = 0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(rr_ptr_q) + k;
            if (sum >= NUM_REQ) sum = sum - NUM_REQ;
            cand = PTR_W'(sum);
            if (rd_valid_i[cand]) begin
                if (!g0_found) begin
                    g0_found = 1'b1;
                    g0_idx   = cand;
                end else if (!g1_found) begin
                    g1_found = 1'b1;
                    g1_idx   = cand;
                end
            end
        end
    end

    assign wr_en   = wr_valid_i && !reset;
    assign grant_b = g0_found && !reset;
    assign grant_a = g1_found && !wr_valid_i && !reset;

    // A port-B read of the address being written would see stale contents.
    assign fwd_hit = wr_en && grant_b &&
                     (req_addr[g0_idx][IDX_BITS-1:0] == wr_addr_i[IDX_BITS-1:0]) &&
                     (req_addr[g0_idx][ADDR_WIDTH-1:IDX_BITS] == wr_addr_i[ADDR_WIDTH-1:IDX_BITS]);

    assign rd_ready_o    = rd_grant;
    assign wr_ready_o    = wr_en;
    assign cache_we_o    = wr_en;
    assign cache_cea_o   = wr_en || grant_a;
    assign cache_ceb_o   = grant_b;
    assign cache_wdata_o = wr_valid_i ? wr_data_i : '0;
    assign cache_addra_o = wr_valid_i ? wr_addr_i : (g1_found ? req_addr[g1_idx] : '0);
    assign cache_addrb_o = g0_found ? req_addr[g0_idx] : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_a)      rr_ptr_d = ptr_inc(g1_idx);
        else if (grant_b) rr_ptr_d = ptr_inc(g0_idx);
    end

    always_comb begin
        rsp_valid_d = rd_grant;
        rsp_data_d  = rsp_data_q;
        rsp_hit_d   = rsp_hit_q;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_b && (int'(g0_idx) == r)) begin
                rsp_data_d[r*DATA_WIDTH +: DATA_WIDTH] = fwd_hit ? wr_data_i : cache_rdatab_i;
                rsp_hit_d[r] = fwd_hit || cache_rhitb_i;
            end else if (grant_a && (int'(g1_idx) == r)) begin
                rsp_data_d[r*DATA_WIDTH +: DATA_WIDTH] = cache_rdataa_i;
                rsp_hit_d[r] = cache_rhita_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_hit_o   = rsp_hit_q;

`ifdef CACHE_ARB_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        logic [32:0] hit_sum, miss_sum;
        hit_sum  = {1'b0, hit_cnt_q};
        miss_sum = {1'b0, miss_cnt_q};
        for (int r = 0; r < NUM_REQ; r++) begin
            if (rsp_valid_q[r] && rsp_hit_q[r])  hit_sum  = hit_sum + 33'd1;
            if (rsp_valid_q[r] && !rsp_hit_q[r]) miss_sum = miss_sum + 33'd1;
        end
        hit_cnt_d  = hit_sum[32]  ? 32'hFFFF_FFFF : hit_sum[31:0];
        miss_cnt_d = miss_sum[32] ? 32'hFFFF_FFFF : miss_sum[31:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_cache_dp_arbiter.sv
// Vector-table bench for cache_dp_arbiter with a behavioural cache and a response scoreboard.
module tb_cache_dp_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  rd_valid_i;
    logic [31:0] rd_addr_i;
    logic [3:0]  rd_ready_o, rsp_valid_o, rsp_hit_o;
    logic [63:0] rsp_data_o;
    logic        wr_valid_i, wr_ready_o;
    logic [7:0]  wr_addr_i, cache_addra_o, cache_addrb_o;
    logic [15:0] wr_data_i, cache_wdata_o, cache_rdataa_i, cache_rdatab_i;
    logic        cache_cea_o, cache_ceb_o, cache_we_o, cache_rhita_i, cache_rhitb_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    cache_dp_arbiter dut (
        .clk(clk), .reset(reset),
        .rd_valid_i(rd_valid_i), .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_hit_o(rsp_hit_o),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_ready_o(wr_ready_o),
        .cache_addra_o(cache_addra_o), .cache_addrb_o(cache_addrb_o),
        .cache_wdata_o(cache_wdata_o), .cache_cea_o(cache_cea_o),
        .cache_ceb_o(cache_ceb_o), .cache_we_o(cache_we_o),
        .cache_rdataa_i(cache_rdataa_i), .cache_rdatab_i(cache_rdatab_i),
        .cache_rhita_i(cache_rhita_i), .cache_rhitb_i(cache_rhitb_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural direct-mapped cache: 4 entries, 6-bit tags.
    logic [15:0] m_data [4];
    logic [5:0]  m_tag  [4];
    logic        m_vld  [4];
    assign cache_rdataa_i = m_data[cache_addra_o[1:0]];
    assign cache_rhita_i  = m_vld[cache_addra_o[1:0]] && (m_tag[cache_addra_o[1:0]] == cache_addra_o[7:2]);
    assign cache_rdatab_i = m_data[cache_addrb_o[1:0]];
    assign cache_rhitb_i  = m_vld[cache_addrb_o[1:0]] && (m_tag[cache_addrb_o[1:0]] == cache_addrb_o[7:2]);

    typedef struct {
        logic [3:0]  rd_valid;
        logic [31:0] rd_addr;
        logic        wr_valid;
        logic [7:0]  wr_addr;
        logic [15:0] wr_data;
        logic [3:0]  exp_ready;
    } vec_t;

    typedef struct {
        int          r;
        logic [15:0] data;
        logic        hit;
    } rsp_t;

    vec_t vecs [16];
    rsp_t sb [$];
    int   total = 0;
    int   bad   = 0;
    int   exp_hits = 0;
    int   exp_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int i, input vec_t v);
        logic [3:0]  exp_mask;
        logic [7:0]  a;
        rsp_t        e;
        rd_valid_i = v.rd_valid;
        rd_addr_i  = v.rd_addr;
        wr_valid_i = v.wr_valid;
        wr_addr_i  = v.wr_addr;
        wr_data_i  = v.wr_data;
        #3;
        check($sformatf("v%0d rd_ready", i), 64'(rd_ready_o), 64'(v.exp_ready));
        check($sformatf("v%0d wr_ready", i), 64'(wr_ready_o), 64'(v.wr_valid));
        check($sformatf("v%0d ports", i), {61'd0, cache_cea_o, cache_ceb_o, cache_we_o},
              {61'd0, v.wr_valid || ($countones(v.exp_ready) == 2), v.exp_ready != 4'd0, v.wr_valid});
        exp_mask = v.exp_ready;
        for (int r = 0; r < 4; r++) begin
            if (v.exp_ready[r]) begin
                a = v.rd_addr[r*8 +: 8];
                e.r = r;
                if (v.wr_valid && a == v.wr_addr) begin
                    e.data = v.wr_data;
                    e.hit  = 1'b1;
                end else begin
                    e.data = m_data[a[1:0]];
                    e.hit  = m_vld[a[1:0]] && (m_tag[a[1:0]] == a[7:2]);
                end
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (v.wr_valid) begin
            m_data[v.wr_addr[1:0]] = v.wr_data;
            m_tag[v.wr_addr[1:0]]  = v.wr_addr[7:2];
            m_vld[v.wr_addr[1:0]]  = 1'b1;
        end
        check($sformatf("v%0d rsp_valid", i), 64'(rsp_valid_o), 64'(exp_mask));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("v%0d rsp_data[%0d]", i, e.r), 64'(rsp_data_o[e.r*16 +: 16]), 64'(e.data));
            check($sformatf("v%0d rsp_hit[%0d]", i, e.r), 64'(rsp_hit_o[e.r]), 64'(e.hit));
            if (e.hit) exp_hits++;
            else       exp_miss++;
        end
        $display("vec %0d: rd_valid=%b wr=%b ready=%b rsp_valid=%b", i, v.rd_valid, v.wr_valid, rd_ready_o, rsp_valid_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] base;
        base = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int k = 0; k < 4; k++) begin
            m_data[k] = 16'h0000;
            m_tag[k]  = 6'd0;
            m_vld[k]  = 1'b0;
        end
        //          rd_valid rd_addr                        wr  wr_addr wr_data   exp_ready
        vecs[0]  = '{4'b1111, base,                          1'b0, 8'h00, 16'h0000, 4'b0011};
        vecs[1]  = '{4'b1111, base,                          1'b0, 8'h00, 16'h0000, 4'b1100};
        vecs[2]  = '{4'b1111, base,                          1'b0, 8'h00, 16'h0000, 4'b0011};
        vecs[3]  = '{4'b0011, {8'h43, 8'h32, 8'h21, 8'hA5}, 1'b1, 8'hA5, 16'h1234, 4'b0001};
        vecs[4]  = '{4'b0100, {8'h43, 8'hB5, 8'h21, 8'h10}, 1'b0, 8'h00, 16'h0000, 4'b0100};
        vecs[5]  = '{4'b0010, {8'h43, 8'h32, 8'hA5, 8'h10}, 1'b0, 8'h00, 16'h0000, 4'b0010};
        vecs[6]  = '{4'b0000, base,                          1'b1, 8'hB5, 16'h5678, 4'b0000};
        vecs[7]  = '{4'b1000, {8'hB5, 8'h32, 8'h21, 8'h10}, 1'b1, 8'h13, 16'hBEEF, 4'b1000};
        vecs[8]  = '{4'b1000, {8'h13, 8'h32, 8'h21, 8'h10}, 1'b0, 8'h00, 16'h0000, 4'b1000};
        vecs[9]  = '{4'b1000, {8'h13, 8'h32, 8'h21, 8'h10}, 1'b0, 8'h00, 16'h0000, 4'b1000};
        vecs[10] = '{4'b0101, {8'h43, 8'h13, 8'h21, 8'hA5}, 1'b1, 8'h20, 16'h0001, 4'b0001};
        vecs[11] = '{4'b0101, {8'h43, 8'h13, 8'h21, 8'hA5}, 1'b0, 8'h00, 16'h0000, 4'b0101};
        vecs[12] = '{4'b0000, base,                          1'b0, 8'h00, 16'h0000, 4'b0000};
        vecs[13] = '{4'b0011, {8'h43, 8'h32, 8'h60, 8'h20}, 1'b0, 8'h00, 16'h0000, 4'b0011};
        vecs[14] = '{4'b0000, base,                          1'b0, 8'h00, 16'h0000, 4'b0000};
        vecs[15] = '{4'b0000, base,                          1'b0, 8'h00, 16'h0000, 4'b0000};

        // Reset with live requests: grants and enables must stay low.
        reset      = 1'b1;
        rd_valid_i = 4'b1111;
        rd_addr_i  = base;
        wr_valid_i = 1'b1;
        wr_addr_i  = 8'h10;
        wr_data_i  = 16'hFFFF;
        #12;
        check("reset rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset rsp_data", rsp_data_o, 64'd0);
        check("reset rsp_hit", 64'(rsp_hit_o), 64'd0);
        check("reset rd_ready", 64'(rd_ready_o), 64'd0);
        check("reset wr_ready", 64'(wr_ready_o), 64'd0);
        check("reset enables", {61'd0, cache_cea_o, cache_ceb_o, cache_we_o}, 64'd0);
        check("reset counters", {hit_cnt_o, miss_cnt_o}, 64'd0);
        $display("reset: rd_ready=%b rsp_valid=%b", rd_ready_o, rsp_valid_o);
        rd_valid_i = 4'b0000;
        wr_valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) apply(i, vecs[i]);

`ifdef CACHE_ARB_STATS_EN
        check("hit_cnt", 64'(hit_cnt_o), 64'(exp_hits));
        check("miss_cnt", 64'(miss_cnt_o), 64'(exp_miss));
`else
        check("hit_cnt", 64'(hit_cnt_o), 64'd0);
        check("miss_cnt", 64'(miss_cnt_o), 64'd0);
`endif
        $display("stats: hit_cnt=%0d miss_cnt=%0d model hits=%0d misses=%0d", hit_cnt_o, miss_cnt_o, exp_hits, exp_miss);

        // Reset arriving in a cycle that grants r1 discards that response.
        rd_valid_i = 4'b0010;
        rd_addr_i  = base;
        #3;
        check("midreset grant", 64'(rd_ready_o), 64'b0010);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("midreset rsp_data", rsp_data_o, 64'd0);
        check("midreset rsp_hit", 64'(rsp_hit_o), 64'd0);
        check("midreset counters", {hit_cnt_o, miss_cnt_o}, 64'd0);
        reset      = 1'b0;
        rd_valid_i = 4'b1111;
        #3;
        check("post-reset rr_ptr", 64'(rd_ready_o), 64'b0011);
        $display("midreset: rsp_valid=%b post ready=%b", rsp_valid_o, rd_ready_o);
        @(posedge clk);
        #1;
        rd_valid_i = 4'b0000;
        check("post-reset rsp_valid", 64'(rsp_valid_o), 64'b0011);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_dp_arbiter.md
# cache_dp_arbiter

Shares one dual-port direct-mapped tag/data cache (`cache_DP`, zero-latency read, write on port A only) between NUM_REQ read requesters and one write requester. Each cycle it grants up to two reads (port B, plus port A when no write), registers each granted read's data and hit flag into per-requester response slots, and forwards same-cycle write data to colliding reads. Sits between the execution-unit operand fetch logic and the cache instance.

## Interface
- NUM_REQ, 4, number of read requesters (2..16)
- IDX_BITS, 2, cache index width (matches cache instance)
- DATA_WIDTH, 16, data word width
- ADDR_WIDTH, 8, full address width (tag = ADDR_WIDTH-IDX_BITS upper bits)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- rd_valid_i  in  NUM_REQ  per-requester read request
- rd_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
- rd_ready_o  out  NUM_REQ  grant this cycle (combinational, depends on rd_valid_i and wr_valid_i)
- rsp_valid_o  out  NUM_REQ  registered response strobe, one cycle
- rsp_data_o  out  NUM_REQ*DATA_WIDTH  registered read data, flattened as above
- rsp_hit_o  out  NUM_REQ  registered tag-hit flag
- wr_valid_i  in  1  write request
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  DATA_WIDTH  write data
- wr_ready_o  out  1  write accepted; equals wr_valid_i
- cache_addra_o, cache_addrb_o  out  ADDR_WIDTH  cache port addresses
- cache_wdata_o  out  DATA_WIDTH  cache write data
- cache_cea_o, cache_ceb_o, cache_we_o  out  1  cache enables / write enable
- cache_rdataa_i, cache_rdatab_i  in  DATA_WIDTH  cache read data
- cache_rhita_i, cache_rhitb_i  in  1  cache tag-hit flags
- hit_cnt_o, miss_cnt_o  out  32  response statistics (see Configuration)

## Operation
- Write priority: wr_valid_i=1 -> port A carries the write (cea=we=1, addra=wr_addr_i, wdata=wr_data_i); wr_ready_o=1 same cycle. No write ever stalls.
- Read arbitration, round-robin pointer rr_ptr (log2 NUM_REQ bits, reset 0):
  - G0 = first requester with rd_valid_i set, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; granted on port B (ceb=1, addrb=its address).
  - G1 = next valid requester after G0 in the same circular order; granted on port A only if wr_valid_i=0 (cea=1, we=0).
  - rd_ready_o set for granted requesters only. Ungranted requesters hold valid and address.
  - rr_ptr <= (last granted index + 1) mod NUM_REQ; unchanged when nothing granted.
- Unused ports: enable 0, address driven 0.
- Response: for each granted requester r, next rising edge sets rsp_valid_o[r]=1, rsp_data_o slot r = cache data of its port, rsp_hit_o[r] = cache hit of its port. Without a new grant, rsp_valid_o[r] returns to 0 next cycle; data/hit slots hold last values.
- Write forwarding: a read granted on port B in the same cycle as a write with identical full address responds with wr_data_i and hit=1 (cache would return pre-write contents). Same index, different tag: cache output used unchanged (old entry, hit per cache compare).
- No response backpressure; requesters must sink rsp_valid_o when it fires.

## Timing
- Grant: combinational, same cycle as request. Read latency: response exactly 1 cycle after grant. Write visible to reads granted from the next cycle onward (or same cycle via forwarding, port B only).
- Reset (asynchronous): rr_ptr=0, rsp_valid_o=0, rsp_data_o=0, rsp_hit_o=0, counters=0. Combinational outputs follow inputs while reset is high except rd_ready_o=0, wr_ready_o=0, all cache enables 0. Reset during a granted cycle discards its response.
- Maximum read throughput: 2/cycle without writes, 1/cycle with writes.

## Configuration
- CACHE_ARB_STATS_EN defined: hit_cnt_o / miss_cnt_o increment per rsp_valid_o bit with rsp_hit_o=1 / 0 respectively (up to 2 per cycle), saturating at 32'hFFFF_FFFF.
- Not defined: counters not built; hit_cnt_o and miss_cnt_o tied to 0. Ports remain.

## Test plan
- Reset then all four requesters valid, no write -> cycle 0 grants r0 (B) and r1 (A), cycle 1 r2/r3, cycle 2 r0/r1; responses one cycle after each grant.
- Write 0x0A5 <- 16'h1234 with r0 reading 0x0A5 same cycle -> r0 granted on B only, rsp_data 16'h1234, hit=1; r1 not granted that cycle.
- Write 0x0A5, then r2 reads 0x0B5 (same index, other tag) next cycle -> rsp_hit_o[2]=0.
- Only r3 valid, rr_ptr=0 -> r3 granted on B, rr_ptr becomes 0; continuous r3 requests granted every cycle.
- Assert reset while r1 granted -> rsp_valid_o stays 0 next cycle, rr_ptr=0, all response slots 0.
- With CACHE_ARB_STATS_EN: 3 hits + 2 misses -> hit_cnt_o=3, miss_cnt_o=2; without macro both read 0.
